bkm_check_scoreboard: RTL

BKM_CHECK_SCOREBOARD -- requirements
Module: bkm_check_scoreboard

---
 rtl/bkm_check_scoreboard_if.sv | 36 +++
 rtl/bkm_check_scoreboard.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bkm_check_scoreboard_if.sv
// bkm_check_scoreboard_if
//   This interface carries the data-step checker's sample bus into the scoreboard,
//   and it carries the report handshake back out again.
//   Ports:
//     master : the checker/consumer side. It drives the sample fields and report_ready,
//              and it reads report_valid.
//     slave  : the scoreboard side. It reads the sample fields and report_ready,
//              and it drives report_valid.
//   Signals:
//     sample_valid             : err/war/delta are valid this cycle
//     err_X, war_X, err_Y, war_Y : per-lane error/warning flags
//     delta_X, delta_Y         : W-bit two's-complement expected-minus-obtained
//     report_valid/report_ready: final-statistics handshake
interface bkm_check_scoreboard_if #(
  parameter int W = 64
);
  logic         sample_valid;
  logic         err_X;
  logic         war_X;
  logic         err_Y;
  logic         war_Y;
  logic [W-1:0] delta_X;
  logic [W-1:0] delta_Y;
  logic         report_valid;
  logic         report_ready;

  modport master (
    output sample_valid, err_X, war_X, err_Y, war_Y, delta_X, delta_Y, report_ready,
    input  report_valid
  );

  modport slave (
    input  sample_valid, err_X, war_X, err_Y, war_Y, delta_X, delta_Y, report_ready,
    output report_valid
  );
endinterface

// File: rtl/bkm_check_scoreboard.sv
// bkm_check_scoreboard
//   This block accumulates the per-sample error/warning flags and the |delta| maxima
//   produced by the data-step checker over one run. A run is the span from start to stop.
//   When the run ends, the block holds the final statistics behind a valid/ready handshake.
//   Ports:
//     clk, srst          : clock, synchronous active-high reset
//     start, stop        : single-cycle run control pulses
//     bus (slave)        : sample bus in, report_valid out, report_ready in
//     busy               : state is RUN
//     n_samples, n_err_X, n_war_X, n_err_Y, n_war_Y : CW-bit saturating counters
//     max_dX, max_dY     : largest unsigned |delta| seen per lane
//     first_err_idx/lane/valid : index and {Y,X} flags of the first error sample
//     pass               : the run ended with at least one sample and no errors
module bkm_check_scoreboard #(
  parameter int W  = 64,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          start,
  input  logic          stop,
  bkm_check_scoreboard_if.slave bus,
  output logic          busy,
  output logic [CW-1:0] n_samples,
  output logic [CW-1:0] n_err_X,
  output logic [CW-1:0] n_war_X,
  output logic [CW-1:0] n_err_Y,
  output logic [CW-1:0] n_war_Y,
  output logic [W-1:0]  max_dX,
  output logic [W-1:0]  max_dY,
  output logic [CW-1:0] first_err_idx,
  output logic [1:0]    first_err_lane,
  output logic          first_err_valid,
  output logic          pass
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t state, state_nxt;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // In IDLE, start takes priority over stop. In RUN, stop takes priority over start.
  // ------------------------------------------------------------------
  always_comb begin
    // NOTE: assign a default before the case; otherwise an uncovered path infers a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)            state_nxt = RUN;
      RUN:     if (stop)             state_nxt = DONE;
      DONE:    if (bus.report_ready) state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    busy             = (state == RUN);
    bus.report_valid = (state == DONE);
  end

  // ------------------------------------------------------------------
  // Datapath control
  // ------------------------------------------------------------------
  logic run_clear;   // statistics are zeroed because a run is (re)starting
  logic accept;      // this cycle's sample is folded into the statistics
  logic finish;      // RUN -> DONE on this edge

  always_comb begin
    run_clear = ((state == IDLE) && start) || ((state == RUN) && start && !stop);
    // A restart inside RUN discards the sample of that cycle. A stop keeps its sample.
    accept    = (state == RUN) && bus.sample_valid && !(start && !stop);
    finish    = (state == RUN) && stop;
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt, input logic en);
    return (en && (cnt != CNT_MAX)) ? cnt + CW'(1) : cnt;
  endfunction

  // Two's-complement magnitude in W bits. The most negative value maps to 2^(W-1),
  // which fits in W unsigned bits.
  function automatic logic [W-1:0] abs_w(input logic [W-1:0] d);
    return d[W-1] ? (~d + W'(1)) : d;
  endfunction

  logic [CW-1:0] n_samples_nxt, n_err_X_nxt, n_war_X_nxt, n_err_Y_nxt, n_war_Y_nxt;
  logic [W-1:0]  abs_dX, abs_dY;
  logic          any_err;

  always_comb begin
    n_samples_nxt = sat_inc(n_samples, accept);
    // An error on a lane hides that lane's warning for the same sample.
    n_err_X_nxt   = sat_inc(n_err_X, accept &&  bus.err_X);
    n_war_X_nxt   = sat_inc(n_war_X, accept && !bus.err_X && bus.war_X);
    n_err_Y_nxt   = sat_inc(n_err_Y, accept &&  bus.err_Y);
    n_war_Y_nxt   = sat_inc(n_war_Y, accept && !bus.err_Y && bus.war_Y);
    abs_dX        = abs_w(bus.delta_X);
    abs_dY        = abs_w(bus.delta_Y);
    any_err       = bus.err_X || bus.err_Y;
  end

  // ------------------------------------------------------------------
  // Statistics registers. They are held from DONE through IDLE until the next start.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (srst || run_clear) begin
      n_samples       <= '0;
      n_err_X         <= '0;
      n_war_X         <= '0;
      n_err_Y         <= '0;
      n_war_Y         <= '0;
      max_dX          <= '0;
      max_dY          <= '0;
      first_err_idx   <= '0;
      first_err_lane  <= '0;
      first_err_valid <= 1'b0;
      pass            <= 1'b0;
    end else begin
      n_samples <= n_samples_nxt;
      n_err_X   <= n_err_X_nxt;
      n_war_X   <= n_war_X_nxt;
      n_err_Y   <= n_err_Y_nxt;
      n_war_Y   <= n_war_Y_nxt;
      if (accept && (abs_dX > max_dX)) max_dX <= abs_dX;
      if (accept && (abs_dY > max_dY)) max_dY <= abs_dY;
      // The first error captures the sample index before the increment,
      // and the capture stays frozen for the rest of the run.
      if (accept && any_err && !first_err_valid) begin
        first_err_idx   <= n_samples;
        first_err_lane  <= {bus.err_Y, bus.err_X};
        first_err_valid <= 1'b1;
      end
      // The verdict uses the post-update counts, so it includes the stop-cycle sample.
      if (finish)
        pass <= (n_samples_nxt != '0) && (n_err_X_nxt == '0) && (n_err_Y_nxt == '0);
    end
  end

endmodule
